// File: rtl/rom_controller_pass.sv
// Boot-time loader: sweeps ROM_PASS once, captures every password word into a table and streams it out.
// Optional blank-slot detection is enabled with the ROM_PASS_BLANK_CHECK_EN macro.
module rom_controller_pass #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 20,
    parameter int DEPTH   = 8,
    parameter int ROM_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         q,
    output logic [ADDR_W-1:0]         address,
    output logic                      done,
    output logic                      pw_valid,
    output logic [ADDR_W-1:0]         pw_index,
    output logic [DATA_W-1:0]         pw_data,
    output logic [DEPTH*DATA_W-1:0]   pw_table
`ifdef ROM_PASS_BLANK_CHECK_EN
    ,
    output logic [DEPTH-1:0]          blank_mask
`endif
);

    typedef enum logic [1:0] {
        SWEEP = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t                          state_r;
    logic [ROM_LAT-1:0]              tag_v_r;
    logic [ROM_LAT-1:0][ADDR_W-1:0]  tag_idx_r;
    logic                            cap_v_s;
    logic [ADDR_W-1:0]               cap_idx_s;

    // The oldest tag lines up with the ROM data currently on q.
    assign cap_v_s   = tag_v_r[ROM_LAT-1];
    assign cap_idx_s = tag_idx_r[ROM_LAT-1];

`ifdef ROM_PASS_BLANK_CHECK_EN
    // An unprogrammed slot reads back as all zeros or all ones.
    function automatic logic is_blank(input logic [DATA_W-1:0] word);
        return (word == {DATA_W{1'b0}}) || (word == {DATA_W{1'b1}});
    endfunction
`endif

    // Sweep FSM, tag pipeline and capture registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= SWEEP;
            address   <= {ADDR_W{1'b0}};
            done      <= 1'b0;
            pw_valid  <= 1'b0;
            pw_index  <= {ADDR_W{1'b0}};
            pw_data   <= {DATA_W{1'b0}};
            pw_table  <= {(DEPTH*DATA_W){1'b0}};
            tag_v_r   <= {ROM_LAT{1'b0}};
            tag_idx_r <= {(ROM_LAT*ADDR_W){1'b0}};
`ifdef ROM_PASS_BLANK_CHECK_EN
            blank_mask <= {DEPTH{1'b0}};
`endif
        end else begin
            for (int i = ROM_LAT - 1; i > 0; i--) begin
                tag_v_r[i]   <= tag_v_r[i-1];
                tag_idx_r[i] <= tag_idx_r[i-1];
            end
            tag_v_r[0]   <= (state_r == SWEEP);
            tag_idx_r[0] <= address;

            if (cap_v_s) begin
                pw_table[cap_idx_s*DATA_W +: DATA_W] <= q;
                pw_data  <= q;
                pw_index <= cap_idx_s;
                pw_valid <= 1'b1;
`ifdef ROM_PASS_BLANK_CHECK_EN
                blank_mask[cap_idx_s] <= is_blank(q);
`endif
            end else begin
                pw_valid <= 1'b0;
            end

            case (state_r)
                SWEEP: begin
                    if (address == LAST_ADDR) begin
                        state_r <= DRAIN;
                    end else begin
                        address <= address + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (cap_v_s && (cap_idx_s == LAST_ADDR)) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    state_r <= DONE;
                end
                default: begin
                    state_r <= SWEEP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_controller_pass.sv
// Directed bench for rom_controller_pass with a two-stage synchronous ROM model and a capture scoreboard.
// Build with ROM_PASS_BLANK_CHECK_EN to also exercise the blank-slot mask (word 3 forced to all ones).
module tb_rom_controller_pass;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 20;
    localparam int DEPTH  = 8;

    logic                    clk;
    logic                    rst;
    logic [DATA_W-1:0]       q;
    logic [ADDR_W-1:0]       address;
    logic                    done;
    logic                    pw_valid;
    logic [ADDR_W-1:0]       pw_index;
    logic [DATA_W-1:0]       pw_data;
    logic [DEPTH*DATA_W-1:0] pw_table;
`ifdef ROM_PASS_BLANK_CHECK_EN
    logic [DEPTH-1:0]        blank_mask;
`endif

    int checks;
    int failures;
    logic [ADDR_W+DATA_W-1:0] sb[$];

    rom_controller_pass dut (
        .clk      (clk),
        .rst      (rst),
        .q        (q),
        .address  (address),
        .done     (done),
        .pw_valid (pw_valid),
        .pw_index (pw_index),
        .pw_data  (pw_data),
`ifdef ROM_PASS_BLANK_CHECK_EN
        .pw_table (pw_table),
        .blank_mask (blank_mask)
`else
        .pw_table (pw_table)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_word(input int k);
        logic [DATA_W-1:0] w;
        w = DATA_W'(20'h11111 * k);
`ifdef ROM_PASS_BLANK_CHECK_EN
        if (k == 3) w = 20'hFFFFF;
`endif
        return w;
    endfunction

    // ROM model: address register then output register.
    logic [ADDR_W-1:0] rom_addr_r = '0;
    always @(posedge clk) begin
        rom_addr_r <= address;
        q          <= rom_word(int'(rom_addr_r));
    end

    task automatic check(input string tag, input logic [DEPTH*DATA_W-1:0] obs,
                         input logic [DEPTH*DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic release_reset();
        sb.delete();
        for (int k = 0; k < DEPTH; k++) sb.push_back({ADDR_W'(k), rom_word(k)});
        rst = 1'b1;
    endtask

    // Sample one edge later (on the falling edge) and compare against edge number n after release.
    task automatic edge_check(input int n);
        logic [ADDR_W+DATA_W-1:0] e;
        @(negedge clk);
        check("address", address, (n < DEPTH - 1) ? n : DEPTH - 1);
        check("pw_valid", pw_valid, (n >= 3 && n <= 10) ? 1 : 0);
        check("done", done, (n >= 10) ? 1 : 0);
        if (pw_valid) begin
            check("sb_nonempty", (sb.size() != 0) ? 1 : 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pw_index", pw_index, e[ADDR_W+DATA_W-1:DATA_W]);
                check("pw_data", pw_data, e[DATA_W-1:0]);
            end
        end
    endtask

    task automatic check_table();
        logic [DEPTH*DATA_W-1:0] exp_tab;
        for (int k = 0; k < DEPTH; k++) exp_tab[k*DATA_W +: DATA_W] = rom_word(k);
        check("table_word7", pw_table[7*DATA_W +: DATA_W], 20'h77777);
        check("table_full", pw_table, exp_tab);
        check("sb_drained", sb.size(), 0);
`ifdef ROM_PASS_BLANK_CHECK_EN
        check("blank_mask", blank_mask, 8'b0000_1001);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_address"}, address, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pw_valid"}, pw_valid, 0);
        check({tag, "_pw_index"}, pw_index, 0);
        check({tag, "_pw_data"}, pw_data, 0);
        check({tag, "_pw_table"}, pw_table, 0);
`ifdef ROM_PASS_BLANK_CHECK_EN
        check({tag, "_blank_mask"}, blank_mask, 0);
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;

        // Reset held low for 5 clocks.
        repeat (5) @(negedge clk);
        check_all_zero("reset");

        // First full load, released mid-cycle.
        release_reset();
        #1;
        check("cycle0_address", address, 0);
        for (int n = 1; n <= 10; n++) edge_check(n);
        check_table();
        for (int n = 11; n <= 30; n++) edge_check(n);

        // Mid-sweep abort at edge 5.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();
        for (int n = 1; n <= 5; n++) edge_check(n);
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (3) @(negedge clk);
        check_all_zero("abort_hold");

        // Full reload after the abort.
        release_reset();
        #1;
        check("reload_cycle0_address", address, 0);
        for (int n = 1; n <= 12; n++) edge_check(n);
        check_table();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
